// File: rtl/mem_system_assoc.sv
// Write-back, write-allocate cache controller with 1- or 2-way set associativity,
// LRU replacement and a fixed-latency read return path from main memory.

module mem_system_assoc_way #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_W-1:0]       index,
    input  logic [$clog2(WORDS)-1:0] rd_word,
    input  logic                     data_we,
    input  logic [$clog2(WORDS)-1:0] wr_word,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     fill_done,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic                     set_dirty,
    output logic                     valid,
    output logic                     dirty,
    output logic [TAG_W-1:0]         tag,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][WORDS];

    // Only state bits need reset; tags and data are qualified by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (set_dirty)
                dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done)
            tag_q[index] <= fill_tag;
        if (data_we)
            data_q[index][wr_word] <= wr_data;
    end

    assign valid   = valid_q[index];
    assign dirty   = dirty_q[index];
    assign tag     = tag_q[index];
    assign rd_data = data_q[index][rd_word];
endmodule

module mem_system_assoc #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8,
    parameter int WORDS   = 4,
    parameter int WAYS    = 2,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall
);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + 1;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WSEL_W:0]   ISS_LAST = (WSEL_W+1)'(WORDS - 1);
    localparam logic [WSEL_W-1:0] RET_LAST = WSEL_W'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMP, S_WB, S_FILL} state_t;

    state_t              state;
    logic [ADDR_W-1:1]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic                req_wr;
    logic                miss_q;
    logic [WAY_W-1:0]    victim_q;
    logic [WSEL_W:0]     iss_cnt;
    logic [WSEL_W-1:0]   ret_cnt;
    logic [MEM_LAT-1:0]  vld_pipe;
    logic [SETS-1:0]     lru_q;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    rtag;
    logic [WSEL_W-1:0]   rword;
    assign idx   = req_addr[OFF_W+INDEX_W-1:OFF_W];
    assign rtag  = req_addr[ADDR_W-1:OFF_W+INDEX_W];
    assign rword = req_addr[OFF_W-1:1];

    logic [WAYS-1:0]              way_valid, way_dirty, hit_vec;
    logic [WAYS-1:0][TAG_W-1:0]   way_tag;
    logic [WAYS-1:0][DATA_W-1:0]  way_rdata;
    logic [WAYS-1:0]              way_we, way_fill, way_set_dirty;
    logic [WSEL_W-1:0]            rd_word, wr_word;
    logic [DATA_W-1:0]            wr_data;

    // During write-back the arrays are read at the issue counter instead of the request word.
    assign rd_word = (state == S_WB) ? iss_cnt[WSEL_W-1:0] : rword;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        mem_system_assoc_way #(
            .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .WORDS(WORDS)
        ) u_way (
            .clk(clk), .rst(rst), .index(idx), .rd_word(rd_word),
            .data_we(way_we[w]), .wr_word(wr_word), .wr_data(wr_data),
            .fill_done(way_fill[w]), .fill_tag(rtag), .set_dirty(way_set_dirty[w]),
            .valid(way_valid[w]), .dirty(way_dirty[w]), .tag(way_tag[w]),
            .rd_data(way_rdata[w])
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == rtag);
    end

    logic             any_hit, comp_hit;
    logic [WAY_W-1:0] hit_idx, vict;

    always_comb begin
        hit_idx = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_idx = WAY_W'(w);
        // Lowest-numbered invalid way wins over the LRU choice.
        vict = (WAYS == 2) ? WAY_W'(lru_q[idx]) : '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!way_valid[w]) vict = WAY_W'(w);
    end

    assign any_hit  = |hit_vec;
    assign comp_hit = (state == S_COMP) && any_hit;

    logic ret_vld, rd_acc, wr_acc, req_ok, req_bad;
    assign ret_vld = vld_pipe[MEM_LAT-1];
    assign mem_wr  = (state == S_WB)   && !iss_cnt[WSEL_W];
    assign mem_rd  = (state == S_FILL) && !iss_cnt[WSEL_W];
    assign rd_acc  = mem_rd && !mem_stall;
    assign wr_acc  = mem_wr && !mem_stall;
    assign req_ok  = (Rd ^ Wr) && !Addr[0];
    assign req_bad = (Rd && Wr) || ((Rd || Wr) && Addr[0]);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_wr) begin
            mem_addr  = {way_tag[victim_q], idx, iss_cnt[WSEL_W-1:0], 1'b0};
            mem_wdata = way_rdata[victim_q];
        end else if (mem_rd) begin
            mem_addr  = {rtag, idx, iss_cnt[WSEL_W-1:0], 1'b0};
        end
    end

    // Illegal requests are answered combinationally, so gate them by reset.
    assign err      = !rst && (state == S_IDLE) && req_bad;
    assign Done     = err || comp_hit;
    assign CacheHit = comp_hit && !miss_q;
    assign DataOut  = comp_hit ? way_rdata[hit_idx] : '0;
    assign Stall    = (state != S_IDLE) && !Done;

    always_comb begin
        way_we        = '0;
        way_fill      = '0;
        way_set_dirty = '0;
        wr_word       = rword;
        wr_data       = req_data;
        if (state == S_FILL) begin
            wr_word = ret_cnt;
            wr_data = mem_rdata;
            if (ret_vld) begin
                way_we[victim_q] = 1'b1;
                if (ret_cnt == RET_LAST) way_fill[victim_q] = 1'b1;
            end
        end else if (comp_hit && req_wr) begin
            way_we[hit_idx]        = 1'b1;
            way_set_dirty[hit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            miss_q   <= 1'b0;
            victim_q <= '0;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
            vld_pipe <= '0;
            lru_q    <= '0;
        end else begin
            vld_pipe <= (MEM_LAT)'({vld_pipe, rd_acc});
            case (state)
                S_IDLE: if (req_ok) begin
                    req_addr <= Addr[ADDR_W-1:1];
                    req_data <= DataIn;
                    req_wr   <= Wr;
                    miss_q   <= 1'b0;
                    state    <= S_COMP;
                end
                S_COMP: if (any_hit) begin
                    if (WAYS == 2) lru_q[idx] <= ~hit_idx[0];
                    state <= S_IDLE;
                end else begin
                    miss_q   <= 1'b1;
                    victim_q <= vict;
                    iss_cnt  <= '0;
                    ret_cnt  <= '0;
                    state    <= (way_valid[vict] && way_dirty[vict]) ? S_WB : S_FILL;
                end
                S_WB: if (wr_acc) begin
                    if (iss_cnt == ISS_LAST) begin
                        iss_cnt <= '0;
                        state   <= S_FILL;
                    end else begin
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                end
                S_FILL: begin
                    if (rd_acc) iss_cnt <= iss_cnt + 1'b1;
                    if (ret_vld) begin
                        ret_cnt <= ret_cnt + 1'b1;
                        if (ret_cnt == RET_LAST) state <= S_COMP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_system_assoc.sv
// Directed bench for mem_system_assoc: memory model with 2-cycle read latency,
// unwritten words read as (byte address ^ 0xC3C3).

module tb_mem_system_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
    logic        Rd, Wr, Done, Stall, CacheHit, err, mem_wr, mem_rd, mem_stall;

    int ncmp = 0, nfail = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [15:0] wmem [logic [14:0]];
    logic [15:0] wlog_a[$], wlog_d[$], rlog_a[$];
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [14:0] a0 = '0, a1 = '0;

    int          r_n;
    logic [15:0] r_dout;
    logic        r_hit, r_err;
    int          rd0, wr0, wq0, rq0;

    always #5 clk = ~clk;

    mem_system_assoc dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    always_comb begin
        if (v1) mem_rdata = wmem.exists(a1) ? wmem[a1] : ({a1, 1'b0} ^ 16'hC3C3);
        else    mem_rdata = 16'h0000;
    end

    always @(posedge clk) begin
        v0 <= mem_rd && !mem_stall;
        a0 <= mem_addr[15:1];
        v1 <= v0;
        a1 <= a0;
        if (mem_rd && mem_wr) both_cnt++;
        if (mem_rd && !mem_stall) begin
            rd_cnt++;
            rlog_a.push_back(mem_addr);
        end
        if (mem_wr && !mem_stall) begin
            wr_cnt++;
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
            wmem[mem_addr[15:1]] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ctl"}, {26'd0, Done, Stall, err, CacheHit, mem_rd, mem_wr}, 32'd0);
        check({tag, "_dout"}, DataOut, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    // Drives one request at a negedge and samples 1 time unit later each cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int stall_at, input logic [15:0] hold_addr,
                          input int rst_at, input logic [15:0] wb_addr, input logic [15:0] wb_data);
        int n;
        rd0 = rd_cnt; wr0 = wr_cnt; wq0 = wlog_a.size(); rq0 = rlog_a.size();
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        n = 0;
        forever begin
            #1;
            if (n == rst_at) begin
                check("pre_rst_mem_wr", mem_wr, 1);
                check("pre_rst_addr", mem_addr, wb_addr);
                check("pre_rst_wdata", mem_wdata, wb_data);
                rst = 1'b1;
                Rd = 1'b0; Wr = 1'b0;
                #1;
                check_zero_outs("mid_rst");
                @(negedge clk);
                rst = 1'b0;
                r_n = n;
                return;
            end
            if (stall_at >= 0 && n >= stall_at && n < stall_at + 5) begin
                mem_stall = 1'b1;
                check("stall_rd_held", mem_rd, 1);
                check("stall_addr_held", mem_addr, hold_addr);
            end else begin
                mem_stall = 1'b0;
            end
            if (Done) break;
            if (n >= 1) begin Rd = 1'b0; Wr = 1'b0; Addr = 16'hFFFF; end
            if (n >= 100) begin
                check("timeout_done", Done, 1);
                break;
            end
            n++;
            @(negedge clk);
        end
        r_n = n; r_dout = DataOut; r_hit = CacheHit; r_err = err;
        Rd = 1'b0; Wr = 1'b0; Addr = 16'hFFFF; mem_stall = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0; mem_stall = 1'b0;
        #12;
        check_zero_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: cold miss then hit
        do_req(1, 0, 16'h0010, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t1_lat", r_n, 8);
        check("t1_hit", r_hit, 0);
        check("t1_data", r_dout, 16'hC3D3);
        check("t1_reads", rd_cnt - rd0, 4);
        check("t1_writes", wr_cnt - wr0, 0);
        check("t1_rd0", rlog_a[rq0], 16'h0010);
        check("t1_rd3", rlog_a[rq0+3], 16'h0016);
        do_req(1, 0, 16'h0010, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t1b_lat", r_n, 1);
        check("t1b_hit", r_hit, 1);
        check("t1b_data", r_dout, 16'hC3D3);
        check("t1b_traffic", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // 2: write-allocate into second way
        do_req(0, 1, 16'h0812, 16'hBEEF, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t2_lat", r_n, 8);
        check("t2_hit", r_hit, 0);
        check("t2_reads", rd_cnt - rd0, 4);
        do_req(1, 0, 16'h0012, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t2b_hit", r_hit, 1);
        check("t2b_data", r_dout, 16'hC3D1);
        do_req(1, 0, 16'h0812, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t2c_lat", r_n, 1);
        check("t2c_hit", r_hit, 1);
        check("t2c_data", r_dout, 16'hBEEF);

        // 3: clean eviction, then dirty eviction with write-back
        do_req(1, 0, 16'h1012, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t3a_lat", r_n, 8);
        check("t3a_hit", r_hit, 0);
        check("t3a_data", r_dout, 16'hD3D1);
        check("t3a_writes", wr_cnt - wr0, 0);
        do_req(1, 0, 16'h0012, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t3b_lat", r_n, 12);
        check("t3b_hit", r_hit, 0);
        check("t3b_data", r_dout, 16'hC3D1);
        check("t3b_writes", wr_cnt - wr0, 4);
        check("t3b_reads", rd_cnt - rd0, 4);
        check("t3b_wa0", wlog_a[wq0], 16'h0810);
        check("t3b_wd0", wlog_d[wq0], 16'hCBD3);
        check("t3b_wa1", wlog_a[wq0+1], 16'h0812);
        check("t3b_wd1", wlog_d[wq0+1], 16'hBEEF);
        check("t3b_wa3", wlog_a[wq0+3], 16'h0816);
        check("t3b_wd3", wlog_d[wq0+3], 16'hCBD5);

        // 4: memory stall in the middle of a fill
        do_req(1, 0, 16'h2020, 16'h0, 3, 16'h2022, -1, 16'h0, 16'h0);
        check("t4_lat", r_n, 13);
        check("t4_hit", r_hit, 0);
        check("t4_data", r_dout, 16'hE3E3);
        check("t4_reads", rd_cnt - rd0, 4);
        check("t4_rd1", rlog_a[rq0+1], 16'h2022);
        check("t4_rd2", rlog_a[rq0+2], 16'h2024);

        // 5: illegal requests
        do_req(1, 1, 16'h0010, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t5a_lat", r_n, 0);
        check("t5a_err", r_err, 1);
        check("t5a_traffic", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        do_req(1, 0, 16'h0011, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t5b_lat", r_n, 0);
        check("t5b_err", r_err, 1);
        do_req(1, 0, 16'h0010, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t5c_lat", r_n, 1);
        check("t5c_hit", r_hit, 1);
        check("t5c_err", r_err, 0);
        check("t5c_data", r_dout, 16'hC3D3);

        // 6: reset during write-back
        do_req(0, 1, 16'h0040, 16'h1111, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t6a_lat", r_n, 8);
        do_req(0, 1, 16'h0840, 16'h2222, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t6b_lat", r_n, 8);
        do_req(1, 0, 16'h1040, 16'h0, -1, 16'h0, 3, 16'h0042, 16'hC381);
        #1;
        check("post_rst_stall", Stall, 0);
        do_req(1, 0, 16'h0010, 16'h0, -1, 16'h0, -1, 16'h0, 16'h0);
        check("t6_lat", r_n, 8);
        check("t6_hit", r_hit, 0);
        check("t6_data", r_dout, 16'hC3D3);

        check("rd_wr_exclusive", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
